// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipe_flopr register pipeline.
// Holds default geometry and the occupancy-count width function.
package pipe_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 3;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: data register, valid bit and advance logic.
// Ports: prev_v/prev_d in, next_adv from downstream, adv/v_nxt/v/d out.
module pipe_stage
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             prev_v,
  input  logic [WIDTH-1:0] prev_d,
  input  logic             next_adv,
  output logic             adv,
  output logic             v_nxt,
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // An empty stage always advances, so bubbles collapse.
  assign adv   = !v || next_adv;
  assign v_nxt = !flush && (adv ? prev_v : v);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v <= 1'b0;
      d <= RESET_VAL;
    end else begin
      v <= v_nxt;
      // Bubbles and flushes leave the data register untouched.
      if (adv && prev_v && !flush)
        d <= prev_d;
    end
  end

endmodule

// File: rtl/pipe_flopr.sv
// DEPTH-stage valid/ready register pipeline with flush and occupancy count.
// Ports: clk, reset(n), in_valid/in_data/in_ready, out_*, flush, count.
module pipe_flopr
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               DEPTH     = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] vn;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] nadv;
  logic [WIDTH-1:0] d [DEPTH];
  logic             in_fire;
  logic [CW-1:0]    cnt_nxt;

  // Downstream advance seen by each stage, built from the
  // registered valids so no combinational loop crosses stages.
  always_comb begin
    logic a;
    a    = out_ready;
    nadv = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      nadv[k] = a;
      a = !v[k] || a;
    end
  end

  assign in_ready = !flush && adv[0];
  assign in_fire  = in_valid && in_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stg
    logic             pv;
    logic [WIDTH-1:0] pd;

    if (i == 0) begin : g_in
      assign pv = in_fire;
      assign pd = in_data;
    end else begin : g_link
      assign pv = v[i-1];
      assign pd = d[i-1];
    end

    pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .prev_v   (pv),
      .prev_d   (pd),
      .next_adv (nadv[i]),
      .adv      (adv[i]),
      .v_nxt    (vn[i]),
      .v        (v[i]),
      .d        (d[i])
    );
  end

  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < DEPTH; k++)
      cnt_nxt = cnt_nxt + CW'(vn[k]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else
      count <= cnt_nxt;
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_flopr.sv
// Random and directed bench for pipe_flopr against a queue-based model.
// Model tracks items by pipeline position; checks every cycle.
module tb_pipe_flopr;

  localparam int D = 3;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_ready;
  logic          flush;
  logic [1:0]    count;

  pipe_flopr #(
    .WIDTH     (W),
    .DEPTH     (D),
    .RESET_VAL ('0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         pos;
    logic [W-1:0] val;
  } item_t;

  item_t        q[$];
  logic [W-1:0] last_out;
  logic [W-1:0] dlv[$];
  int           checks = 0;
  int           errors = 0;
  logic         s_ov;
  logic [W-1:0] s_od;
  logic [1:0]   s_cnt;
  logic         s_ir;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Position 0 is free after this cycle's movement.
  function automatic logic m_in_ready();
    int lim;
    int s;
    if (flush) return 1'b0;
    lim = D;
    s = 0;
    if (q.size() > 0 && q[0].pos == D - 1 && out_ready) s = 1;
    for (int k = s; k < q.size(); k++) begin
      int p;
      p = q[k].pos + 1;
      if (p > lim - 1) p = lim - 1;
      lim = p;
    end
    return lim > 0;
  endfunction

  task automatic m_clear();
    q.delete();
    last_out = '0;
  endtask

  task automatic m_step();
    logic rdy;
    int   lim;
    if (!reset) begin
      m_clear();
      return;
    end
    rdy = m_in_ready();
    lim = D;
    if (q.size() > 0 && q[0].pos == D - 1 && out_ready)
      void'(q.pop_front());
    for (int k = 0; k < q.size(); k++) begin
      int p;
      p = q[k].pos + 1;
      if (p > lim - 1) p = lim - 1;
      q[k].pos = p;
      lim = p;
    end
    if (flush)
      q.delete();
    else if (in_valid && rdy)
      q.push_back('{0, in_data});
    if (!flush && q.size() > 0 && q[0].pos == D - 1)
      last_out = q[0].val;
  endtask

  task automatic step();
    @(negedge clk);
    s_ov  = out_valid;
    s_od  = out_data;
    s_cnt = count;
    s_ir  = in_ready;
    chk("out_valid", W'(out_valid),
        W'(q.size() > 0 && q[0].pos == D - 1));
    chk("out_data", out_data, last_out);
    chk("count", W'(count), W'(q.size()));
    chk("in_ready", W'(in_ready), W'(m_in_ready()));
    if (reset && out_valid && out_ready) dlv.push_back(out_data);
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic push(input logic [W-1:0] x);
    in_valid = 1'b1;
    in_data  = x;
    step();
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    out_ready = 1'b1;
    flush     = 1'b0;
    m_clear();

    repeat (3) step();
    chk("rst_ov", W'(s_ov), '0);
    chk("rst_od", s_od, '0);
    chk("rst_cnt", W'(s_cnt), '0);
    chk("rst_ir", W'(s_ir), W'(1));
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (4) step();
    chk("rst_empty", W'(s_ov), '0);

    push(32'h1);
    push(32'h2);
    push(32'h3);
    in_valid = 1'b0;
    step();
    chk("lat_ov", W'(s_ov), W'(1));
    chk("lat_d1", s_od, 32'h1);
    step();
    chk("str_d2", s_od, 32'h2);
    step();
    chk("str_d3", s_od, 32'h3);
    step();
    chk("str_end", W'(s_ov), '0);

    out_ready = 1'b0;
    dlv.delete();
    push(32'd10);
    push(32'd20);
    push(32'd30);
    push(32'd40);
    chk("bp_cnt", W'(s_cnt), W'(3));
    chk("bp_ir", W'(s_ir), '0);
    step();
    chk("bp_hold", W'(s_ir), '0);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    chk("bp_n", W'(dlv.size()), W'(4));
    for (int k = 0; k < 4 && k < dlv.size(); k++)
      chk("bp_order", dlv[k], W'(10 * (k + 1)));

    out_ready = 1'b0;
    push(32'd5);
    in_valid = 1'b0;
    repeat (2) step();
    push(32'd6);
    in_valid = 1'b0;
    repeat (2) step();
    chk("bub_cnt", W'(s_cnt), W'(2));
    chk("bub_od", s_od, 32'd5);
    out_ready = 1'b1;
    repeat (4) step();

    out_ready = 1'b0;
    dlv.delete();
    push(32'h11);
    push(32'h22);
    push(32'h33);
    in_valid = 1'b0;
    step();
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'd7;
    step();
    chk("fl_ir", W'(s_ir), '0);
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl_cnt", W'(s_cnt), '0);
    chk("fl_ov", W'(s_ov), '0);
    repeat (4) step();
    chk("fl_none", W'(dlv.size()), '0);

    out_ready = 1'b0;
    push(32'hA1);
    push(32'hA2);
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    chk("mr_ov", W'(out_valid), '0);
    chk("mr_cnt", W'(count), '0);
    m_clear();
    step();
    reset = 1'b1;
    step();

    for (int n = 0; n < 3000; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      if (!reset) begin
        reset = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0;
        m_clear();
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
